// File: rtl/spike_mask_pkg.sv
// spike_mask shared definitions: counter sizing, parameter limits, state enum.
// Imported by spike_mask and spike_mask_tick_gen.
package spike_mask_pkg;

    localparam int P_CLK_NOM_MIN   = 1;
    localparam int P_CLK_NOM_MAX   = 255;
    localparam int P_SPIKE_NOM_MIN = 1;
    localparam int P_SPIKE_NOM_MAX = 32;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    // Bits needed to hold values 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spike_mask_tick_gen.sv
// Level-2 timebase tick generator: 2-flop synchronizer and rising-edge detect.
// Emits a one-cycle o_tick; a level already high out of reset gives no tick.
module spike_mask_tick_gen
    import spike_mask_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_lvl,
    output logic o_tick
);

    logic       sync1_q;
    logic       sync2_q;
    logic       prev_q;
    logic [2:0] fill_q;

    // Synchronizer, edge history and a fill marker so that prev_q only
    // counts once it holds a genuine sample rather than its reset value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            fill_q  <= '0;
        end else begin
            sync1_q <= i_lvl;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            fill_q  <= {fill_q[1:0], 1'b1};
        end
    end

    assign o_tick = sync2_q & ~prev_q & fill_q[2];

endmodule

// File: rtl/spike_mask.sv
// spike_mask: retriggerable activity window driven by spike lines and a level-2 tick.
// Optional SPIKE_MASK_LATCH_EN adds o_spike_mask, a sticky per-line record of the window.
module spike_mask
    import spike_mask_pkg::*;
#(
    parameter int p_clk_nom   = 5,
    parameter int p_spike_nom = 4
) (
    input  logic                   i_clk_tst,
    input  logic                   i_rst_n,
    input  logic                   i_clk_lvl_2,
    input  logic [p_spike_nom-1:0] i_spike_in,
`ifdef SPIKE_MASK_LATCH_EN
    output logic [p_spike_nom-1:0] o_spike_mask,
`endif
    output logic                   o_active
);

    localparam int            CW     = clog2(p_clk_nom + 1);
    localparam logic [CW-1:0] RELOAD = CW'(p_clk_nom);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_e        state_q;
    state_e        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick;
    logic          spike_ev;
    logic          expire;

    spike_mask_tick_gen u_tick (
        .i_clk   (i_clk_tst),
        .i_rst_n (i_rst_n),
        .i_lvl   (i_clk_lvl_2),
        .o_tick  (tick)
    );

    assign spike_ev = |i_spike_in;
    assign expire   = tick && (cnt_q == ONE);

    // State and hold counter registers.
    always_ff @(posedge i_clk_tst or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: a spike reloads (beats a tick), a tick counts down to IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (spike_ev) begin
            cnt_d   = RELOAD;
            state_d = ACTIVE;
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) begin
                state_d = IDLE;
            end
        end
    end

    assign o_active = (state_q == ACTIVE);

`ifdef SPIKE_MASK_LATCH_EN
    logic [p_spike_nom-1:0] mask_q;
    logic [p_spike_nom-1:0] mask_d;

    // Sticky per-line mask register.
    always_ff @(posedge i_clk_tst or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    // Accumulate while active; a spike on the expiry edge starts a fresh mask.
    always_comb begin
        mask_d = mask_q;
        if (spike_ev) begin
            if (expire || (state_q == IDLE)) begin
                mask_d = i_spike_in;
            end else begin
                mask_d = mask_q | i_spike_in;
            end
        end else if (expire) begin
            mask_d = '0;
        end
    end

    assign o_spike_mask = mask_q;
`endif

endmodule

// File: tb/tb_spike_mask.sv
// Directed bench for spike_mask: reset, window length, retrigger,
// reload-vs-tick priority, async reset; mask checks with SPIKE_MASK_LATCH_EN.
module tb_spike_mask;

    logic       clk_tst;
    logic       rst_n;
    logic       clk_lvl_2;
    logic [3:0] spike;
    logic       active;
`ifdef SPIKE_MASK_LATCH_EN
    logic [3:0] smask;
`endif

    int checks   = 0;
    int failures = 0;

    spike_mask #(
        .p_clk_nom   (5),
        .p_spike_nom (4)
    ) dut (
        .i_clk_tst   (clk_tst),
        .i_rst_n     (rst_n),
        .i_clk_lvl_2 (clk_lvl_2),
        .i_spike_in  (spike),
`ifdef SPIKE_MASK_LATCH_EN
        .o_spike_mask(smask),
`endif
        .o_active    (active)
    );

    // Posedges at 5,15,25..; lvl2 rises at 20,60,100.. so the tick is
    // consumed on posedges with t%40==5 (negedge before: t%40==0).
    initial begin
        clk_tst = 1'b0;
        forever #5 clk_tst = ~clk_tst;
    end

    initial begin
        clk_lvl_2 = 1'b0;
        forever #20 clk_lvl_2 = ~clk_lvl_2;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One-cycle spike sampled on the posedge between two negedges.
    task automatic pulse(input logic [3:0] m);
        @(negedge clk_tst);
        spike = m;
        @(negedge clk_tst);
        spike = 4'b0000;
        check("rise", {31'd0, active}, 32'd1);
    endtask

    // Negedge samples with o_active high, counting the current one; bounded.
    task automatic measure(output int len);
        len = 1;
        while (active && len < 60) begin
            @(negedge clk_tst);
            if (active) len++;
        end
    endtask

    int len;
    int lows;

    initial begin
        rst_n = 1'b0;
        spike = 4'b0000;

        repeat (9) begin
            @(negedge clk_tst);
            check("rst_active", {31'd0, active}, 32'd0);
        end
        #5 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk_tst);
            check("post_rst_idle", {31'd0, active}, 32'd0);
        end

        pulse(4'b0001);
        measure(len);
        check("single_len", {31'd0, (len >= 16 && len <= 20)}, 32'd1);
        check("single_cnt0", 32'(dut.cnt_q), 32'd0);

        for (int i = 0; i < 4; i++) begin
            pulse(4'b0001 << i);
            measure(len);
            check("line_len", {31'd0, (len >= 16 && len <= 20)}, 32'd1);
            repeat (10) @(negedge clk_tst);
            check("gap_low", {31'd0, active}, 32'd0);
        end

        pulse(4'b0100);
        lows = 0;
        repeat (7) begin
            @(negedge clk_tst);
            if (!active) lows++;
        end
        pulse(4'b1000);
        check("retrig_cont", 32'(lows), 32'd0);
        measure(len);
        check("retrig_len", {31'd0, (len >= 16 && len <= 20)}, 32'd1);

        // Reload on a tick edge, then spike exactly when counter=1 meets a tick.
        do @(negedge clk_tst); while (($time % 40) != 0);
        spike = 4'b0001;
        @(negedge clk_tst);
        spike = 4'b0000;
        lows = 0;
        repeat (19) begin
            @(negedge clk_tst);
            if (!active) lows++;
        end
        check("coinc_pre", 32'(lows), 32'd0);
        check("coinc_cnt1", 32'(dut.cnt_q), 32'd1);
        spike = 4'b0010;
        @(negedge clk_tst);
        spike = 4'b0000;
        check("coinc_hold", {31'd0, active}, 32'd1);
        measure(len);
        check("coinc_len", 32'(len), 32'd20);

`ifdef SPIKE_MASK_LATCH_EN
        pulse(4'b0001);
        check("mask_first", {28'd0, smask}, 32'h1);
        repeat (3) @(negedge clk_tst);
        pulse(4'b0010);
        check("mask_acc", {28'd0, smask}, 32'h3);
        measure(len);
        check("mask_clear", {28'd0, smask}, 32'h0);
`endif

        pulse(4'b0011);
        repeat (3) @(negedge clk_tst);
`ifdef SPIKE_MASK_LATCH_EN
        check("mask_pre_rst", {28'd0, smask}, 32'h3);
`endif
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {31'd0, active}, 32'd0);
`ifdef SPIKE_MASK_LATCH_EN
        check("rst_mask", {28'd0, smask}, 32'h0);
`endif
        @(negedge clk_tst);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_tst);
        check("rst_idle", {31'd0, active}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
